ks_prefix_adder_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready flow control.

---
 rtl/ks_prefix_adder_pipe.sv | 131 +++++++++++++
 tb/tb_ks_prefix_adder_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ks_prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, KGP carry encoding, valid/ready flow control.
// Define KSA_OVF_EN to add the registered signed-overflow output out_ovf.
module ks_prefix_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [TAG_W-1:0] out_tag
`ifdef KSA_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = LEVELS + 2;
    localparam int LAST   = LAT - 2;

    localparam logic [1:0] KGP_K = 2'b00;
    localparam logic [1:0] KGP_P = 2'b01;
    localparam logic [1:0] KGP_G = 2'b11;

    // Index 0 holds position -1 (carry-in); index i+1 holds bit i.
    typedef logic [WIDTH:0][1:0] kgp_vec_t;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] x0_d;
    kgp_vec_t         pre_d [0:LAST];
    kgp_vec_t         pre_q [0:LAST];
    logic [WIDTH-1:0] x_q   [0:LAST];
    logic [TAG_W-1:0] tag_q [0:LAST];
    logic [LAST:0]    v_q;

    logic [WIDTH-1:0] carry;
    logic [1:0]       cout_kgp;
    logic             cout;
    logic [WIDTH:0]   sum_d;

    logic             out_valid_q;
    logic [WIDTH:0]   out_sum_q;
    logic [TAG_W-1:0] out_tag_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign b_eff       = in_sub ? ~in_b : in_b;
    assign x0_d        = in_a ^ b_eff;
    assign pre_d[0][0] = (in_sub || in_cin) ? KGP_G : KGP_K;

    genvar gi, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_kgp
            assign pre_d[0][gi+1] = {in_a[gi] & b_eff[gi], in_a[gi] | b_eff[gi]};
        end

        for (gi = 1; gi <= LAST; gi++) begin : g_level
            localparam int D = 1 << (gi - 1);
            for (gk = 0; gk <= WIDTH; gk++) begin : g_pos
                if (gk >= D) begin : g_comb
                    assign pre_d[gi][gk] = (pre_q[gi-1][gk] == KGP_P) ? pre_q[gi-1][gk-D]
                                                                       : pre_q[gi-1][gk];
                end else begin : g_pass
                    assign pre_d[gi][gk] = pre_q[gi-1][gk];
                end
            end
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_carry
            assign carry[gi] = (pre_q[LAST][gi] == KGP_G);
        end
    endgenerate

    // With a power-of-two WIDTH the top span stops just short of the carry-in,
    // so one closing combine against position -1 resolves the carry out.
    assign cout_kgp = (pre_q[LAST][WIDTH] == KGP_P) ? pre_q[LAST][0] : pre_q[LAST][WIDTH];
    assign cout     = (cout_kgp == KGP_G);
    assign sum_d    = {cout, x_q[LAST] ^ carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            v_q      <= {v_q[LAST-1:0], in_valid};
            pre_q[0] <= pre_d[0];
            x_q[0]   <= x0_d;
            tag_q[0] <= in_tag;
            for (int s = 1; s <= LAST; s++) begin
                pre_q[s] <= pre_d[s];
                x_q[s]   <= x_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
            out_valid_q <= v_q[LAST];
            out_sum_q   <= sum_d;
            out_tag_q   <= tag_q[LAST];
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_tag   = out_tag_q;

`ifdef KSA_OVF_EN
    logic out_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf_q <= 1'b0;
        end else if (adv) begin
            out_ovf_q <= carry[WIDTH-1] ^ cout;
        end
    end

    assign out_ovf = out_ovf_q;
`endif

endmodule

// File: tb/tb_ks_prefix_adder_pipe.sv
// Directed and scoreboarded bench for ks_prefix_adder_pipe (WIDTH=16, TAG_W=4, LAT=6).
module tb_ks_prefix_adder_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic [3:0]  out_tag;
`ifdef KSA_OVF_EN
    logic        out_ovf;
`endif

    int errors = 0;
    int checks = 0;

    ks_prefix_adder_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_tag(out_tag)
`ifdef KSA_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic sub);
        logic [15:0] be;
        be = sub ? ~b : b;
        return {1'b0, a} + {1'b0, be} + 17'(sub ? 1'b1 : cin);
    endfunction

    function automatic logic model_ovf(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] s;
        be = sub ? ~b : b;
        s  = model_sum(a, b, cin, sub);
        return (a[15] == be[15]) && (s[15] != a[15]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: measures latency and checks the result fields.
    task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub, input logic [3:0] tag,
                              input logic [16:0] exp_sum, input logic exp_ovf);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        $display("op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h tag=%0d after %0d cycles",
                 name, a, b, cin, sub, out_sum, out_tag, n);
        check({name, "_lat"}, 32'(n), 32'd6);
        check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
`ifdef KSA_OVF_EN
        check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("op %s has no overflow reference", name);
`endif
        tick();
    endtask

    logic [16:0] q_sum [$];
    logic [3:0]  q_tag [$];
    logic        q_ovf [$];

    initial begin
        logic [16:0] held_sum;
        logic [3:0]  held_tag;
        logic [16:0] e_sum;
        logic [3:0]  e_tag;
        logic        e_ovf;
        int sent;
        int recv;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        held_sum = '0; held_tag = '0;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        tick();

        run_single("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd3,  17'h1_0000, 1'b0);
        run_single("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 4'd5,  17'h0_FFFE, 1'b0);
        run_single("sub_pos",   16'h0007, 16'h0005, 1'b0, 1'b1, 4'd6,  17'h1_0002, 1'b0);
        run_single("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd9,  17'h0_8000, 1'b1);
        run_single("ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 4'd10, 17'h1_0000, 1'b1);
        run_single("add_cin",   16'h1234, 16'h0FFF, 1'b1, 1'b0, 4'd12, 17'h0_2234, 1'b0);
        run_single("sub_equal", 16'h8000, 16'h8000, 1'b1, 1'b1, 4'd15, 17'h1_0000, 1'b0);

        // Back-to-back stream with a 10-cycle output stall in the middle.
        sent = 0;
        recv = 0;
        for (int c = 0; c < 400 && recv < 100; c++) begin
            out_ready = !(c >= 40 && c < 50);
            if (sent < 100) begin
                in_valid = 1'b1;
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
                in_cin   = 1'($urandom_range(0, 1));
                in_sub   = 1'($urandom_range(0, 1));
                in_tag   = 4'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 6 && c < 50) check("stream_full", 32'(out_valid), 32'd1);
            if (c == 40) begin
                held_sum = out_sum;
                held_tag = out_tag;
            end
            if (c >= 40 && c < 50) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (c > 40) begin
                    check("stall_hold_sum", 32'(out_sum), 32'(held_sum));
                    check("stall_hold_tag", 32'(out_tag), 32'(held_tag));
                end
            end
            if (out_valid && out_ready) begin
                if (q_sum.size() == 0) begin
                    check("stream_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    e_sum = q_sum.pop_front();
                    e_tag = q_tag.pop_front();
                    e_ovf = q_ovf.pop_front();
                    $display("stream rx %0d sum=%h tag=%0d exp sum=%h tag=%0d",
                             recv, out_sum, out_tag, e_sum, e_tag);
                    check("stream_sum", 32'(out_sum), 32'(e_sum));
                    check("stream_tag", 32'(out_tag), 32'(e_tag));
`ifdef KSA_OVF_EN
                    check("stream_ovf", 32'(out_ovf), 32'(e_ovf));
`endif
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q_sum.push_back(model_sum(in_a, in_b, in_cin, in_sub));
                q_tag.push_back(in_tag);
                q_ovf.push_back(model_ovf(in_a, in_b, in_cin, in_sub));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream_recv_count", 32'(recv), 32'd100);
        check("stream_queue_left", 32'(q_sum.size()), 32'd0);

        // Reset with four operations in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = 16'(i + 1); in_b = 16'h0100; in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        $display("reset mid-stream: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
